// File: rtl/ifetch_prefetch_queue_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifetch_prefetch_queue_if : ROM, redirect and decode-side bundle  |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
interface ifetch_prefetch_queue_if #(
  parameter int ADDR_W = 32
);
  logic              imem_req;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst_data;
  logic [ADDR_W-1:0] inst_pc;
  logic [ADDR_W-1:0] inst_pc4;

  modport master (
    output imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4,
    input  imem_rdata, redirect_valid, redirect_pc, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst_data, inst_pc, inst_pc4,
    output imem_rdata, redirect_valid, redirect_pc, inst_ready
  );
endinterface
`default_nettype wire

// File: rtl/ifetch_prefetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | ifetch_prefetch_queue : fetch PC owner + prefetch FIFO to decode |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module ifetch_prefetch_queue #(
  parameter int                ADDR_W   = 32,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = '0,
  parameter logic [ADDR_W-1:0] PC_LIMIT = 32'h0000_FFFC
) (
  input  wire logic                       clk,
  input  wire logic                       reset,
  input  wire logic                       run,
  ifetch_prefetch_queue_if.master         bus,
  output logic [$clog2(DEPTH+1)-1:0]      occupancy,
  output logic                            halted
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic              rsp_pending_q, rsp_pending_d;
  logic [ADDR_W-1:0] rsp_pc_q, rsp_pc_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              halted_q, halted_d;
  logic [31:0]       last_data_q, last_data_d;
  logic [ADDR_W-1:0] last_pc_q, last_pc_d;

  logic [31:0]       fifo_data_q [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q   [DEPTH];

  logic              w_req;
  logic [ADDR_W-1:0] w_addr;
  logic              w_push;
  logic              w_pop;
  logic              w_valid;
  logic              w_credit;
  logic [CNT_W:0]    w_inflight;
  logic [ADDR_W-1:0] w_target;
  logic              unused_pc_lsbs;

  assign w_target       = {bus.redirect_pc[ADDR_W-1:2], 2'b00};
  assign unused_pc_lsbs = ^bus.redirect_pc[1:0];
  assign w_valid        = (count_q != '0);
  // Reserve a slot for the read already in flight so the queue can never overflow.
  assign w_inflight     = {1'b0, count_q} + {{CNT_W{1'b0}}, rsp_pending_q};
  assign w_credit       = (w_inflight < (CNT_W+1)'(DEPTH));

  always_comb begin
    fetch_pc_d    = fetch_pc_q;
    rsp_pending_d = 1'b0;
    rsp_pc_d      = rsp_pc_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    count_d       = count_q;
    halted_d      = halted_q;
    last_data_d   = last_data_q;
    last_pc_d     = last_pc_q;
    w_push        = 1'b0;
    w_pop         = 1'b0;
    w_req         = 1'b0;
    w_addr        = fetch_pc_q;

    if (w_valid) begin
      last_data_d = fifo_data_q[rd_ptr_q];
      last_pc_d   = fifo_pc_q[rd_ptr_q];
    end

    if (reset) begin
      w_addr = RESET_PC;
    end else if (!run) begin
      fetch_pc_d = RESET_PC;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
      count_d    = '0;
      halted_d   = 1'b0;
    end else if (bus.redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
      if (w_target <= PC_LIMIT) begin
        w_req         = 1'b1;
        w_addr        = w_target;
        rsp_pending_d = 1'b1;
        rsp_pc_d      = w_target;
        fetch_pc_d    = w_target + ADDR_W'(4);
        // Landing exactly on the limit still fetches it, but nothing after.
        halted_d      = (w_target == PC_LIMIT);
      end else begin
        halted_d = 1'b1;
      end
    end else begin
      w_push = rsp_pending_q;
      w_pop  = w_valid & bus.inst_ready;
      if (!halted_q && w_credit) begin
        w_req         = 1'b1;
        rsp_pending_d = 1'b1;
        rsp_pc_d      = fetch_pc_q;
        if (fetch_pc_q == PC_LIMIT) begin
          halted_d = 1'b1;
        end else begin
          fetch_pc_d = fetch_pc_q + ADDR_W'(4);
        end
      end
      if (w_push) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(w_push) - CNT_W'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_q    <= RESET_PC;
      rsp_pending_q <= 1'b0;
      rsp_pc_q      <= RESET_PC;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      halted_q      <= 1'b0;
      last_data_q   <= '0;
      last_pc_q     <= RESET_PC;
    end else begin
      fetch_pc_q    <= fetch_pc_d;
      rsp_pending_q <= rsp_pending_d;
      rsp_pc_q      <= rsp_pc_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      halted_q      <= halted_d;
      last_data_q   <= last_data_d;
      last_pc_q     <= last_pc_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      fifo_data_q[wr_ptr_q] <= bus.imem_rdata;
      fifo_pc_q[wr_ptr_q]   <= rsp_pc_q;
    end
  end

  // Empty queue shows the most recent head rather than a stale slot.
  assign bus.imem_req   = w_req;
  assign bus.imem_addr  = w_addr;
  assign bus.inst_valid = w_valid;
  assign bus.inst_data  = w_valid ? fifo_data_q[rd_ptr_q] : last_data_q;
  assign bus.inst_pc    = w_valid ? fifo_pc_q[rd_ptr_q] : last_pc_q;
  assign bus.inst_pc4   = bus.inst_pc + ADDR_W'(4);
  assign occupancy      = count_q;
  assign halted         = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_ifetch_prefetch_queue.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_ifetch_prefetch_queue : directed bench, ROM[i] = i            |
// | Revision: 1.0                                                    |
// +------------------------------------------------------------------+
module tb_ifetch_prefetch_queue;
  localparam int          ADDR_W = 32;
  localparam int          DEPTH  = 4;
  localparam logic [31:0] LIMIT  = 32'h0000_03FC;

  logic       clk = 1'b0;
  logic       reset;
  logic       run;
  logic [2:0] occupancy;
  logic       halted;
  int         errors = 0;
  int         checks = 0;

  ifetch_prefetch_queue_if #(.ADDR_W(ADDR_W)) bus ();

  ifetch_prefetch_queue #(
    .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RESET_PC(32'h0), .PC_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .reset(reset), .run(run), .bus(bus), .occupancy(occupancy), .halted(halted)
  );

  always #5 clk = ~clk;

  // Word-indexed ROM; junk when not requested so spurious writes are visible.
  always @(posedge clk) bus.imem_rdata <= bus.imem_req ? (bus.imem_addr >> 2) : 32'hFFFF_FFFF;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b0;
    bus.redirect_valid = 1'b0; bus.redirect_pc = '0; bus.inst_ready = 1'b0;
    repeat (3) step();
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %0b want 0", bus.imem_req); end
    checks++; if (bus.imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %0h want 0", bus.imem_addr); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %0b want 0", bus.inst_valid); end
    checks++; if (bus.inst_data !== 32'h0) begin errors++; $display("FAIL reset_data: got %0h want 0", bus.inst_data); end
    checks++; if (bus.inst_pc !== 32'h0) begin errors++; $display("FAIL reset_pc: got %0h want 0", bus.inst_pc); end
    checks++; if (bus.inst_pc4 !== 32'h4) begin errors++; $display("FAIL reset_pc4: got %0h want 4", bus.inst_pc4); end
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL reset_occ: got %0d want 0", occupancy); end
    checks++; if (halted !== 1'b0) begin errors++; $display("FAIL reset_halted: got %0b want 0", halted); end
  endtask

  task automatic test_stream();
    reset = 1'b0; run = 1'b1; bus.inst_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL stream_first_req: got %0b/%0h want 1/0", bus.imem_req, bus.imem_addr); end
    for (int k = 1; k <= 12; k++) begin
      step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(4*k)) begin errors++; $display("FAIL stream_req c%0d: got %0b/%0h want 1/%0h", k, bus.imem_req, bus.imem_addr, 4*k); end
      if (k < 2) begin
        checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL stream_early_valid c%0d: got %0b want 0", k, bus.inst_valid); end
      end else begin
        checks++; if (bus.inst_valid !== 1'b1) begin errors++; $display("FAIL stream_valid c%0d: got %0b want 1", k, bus.inst_valid); end
        checks++; if (bus.inst_pc !== 32'(4*(k-2))) begin errors++; $display("FAIL stream_pc c%0d: got %0h want %0h", k, bus.inst_pc, 4*(k-2)); end
        checks++; if (bus.inst_data !== 32'(k-2)) begin errors++; $display("FAIL stream_data c%0d: got %0h want %0h", k, bus.inst_data, k-2); end
        checks++; if (bus.inst_pc4 !== 32'(4*(k-1))) begin errors++; $display("FAIL stream_pc4 c%0d: got %0h want %0h", k, bus.inst_pc4, 4*(k-1)); end
      end
    end
  endtask

  task automatic test_backpressure();
    int nreq;
    nreq = 0;
    bus.inst_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (i > 0) step();
      bus.redirect_valid = (i == 0); bus.redirect_pc = 32'h40;
      #1;
      if (i == 0) begin
        checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h40) begin errors++; $display("FAIL bp_redirect_req: got %0b/%0h want 1/40", bus.imem_req, bus.imem_addr); end
      end
      if (bus.imem_req === 1'b1) nreq++;
    end
    checks++; if (nreq !== 4) begin errors++; $display("FAIL bp_req_count: got %0d want 4", nreq); end
    checks++; if (occupancy !== 3'd4) begin errors++; $display("FAIL bp_occ_full: got %0d want 4", occupancy); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL bp_req_blocked: got %0b want 0", bus.imem_req); end
    step();
    bus.inst_ready = 1'b1;
    #1;
    for (int j = 0; j < 8; j++) begin
      if (j > 0) step();
      checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'(32'h40 + 4*j)) begin errors++; $display("FAIL bp_drain_pc d%0d: got %0b/%0h want 1/%0h", j, bus.inst_valid, bus.inst_pc, 32'h40 + 4*j); end
      checks++; if (bus.inst_data !== 32'(32'h10 + j)) begin errors++; $display("FAIL bp_drain_data d%0d: got %0h want %0h", j, bus.inst_data, 32'h10 + j); end
    end
  endtask

  task automatic test_redirect_flush();
    step();
    bus.inst_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h80;
    #1;
    checks++; if (bus.imem_addr !== 32'h80) begin errors++; $display("FAIL fl_first_addr: got %0h want 80", bus.imem_addr); end
    step(); bus.redirect_valid = 1'b0;
    repeat (3) step();
    checks++; if (occupancy !== 3'd3) begin errors++; $display("FAIL fl_occ_before: got %0d want 3", occupancy); end
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL fl_credit_block: got %0b want 0", bus.imem_req); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; bus.inst_ready = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h100) begin errors++; $display("FAIL fl_redirect_req: got %0b/%0h want 1/100", bus.imem_req, bus.imem_addr); end
    step(); bus.redirect_valid = 1'b0; #1;
    checks++; if (occupancy !== 3'd0) begin errors++; $display("FAIL fl_occ_after: got %0d want 0", occupancy); end
    checks++; if (bus.inst_valid !== 1'b0) begin errors++; $display("FAIL fl_no_stale: got %0b want 0", bus.inst_valid); end
    checks++; if (bus.imem_addr !== 32'h104) begin errors++; $display("FAIL fl_next_addr: got %0h want 104", bus.imem_addr); end
    step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h100 || bus.inst_data !== 32'h40) begin errors++; $display("FAIL fl_target_head: got %0b/%0h/%0h want 1/100/40", bus.inst_valid, bus.inst_pc, bus.inst_data); end
  endtask

  task automatic test_redirect_align();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h202;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h200) begin errors++; $display("FAIL al_addr: got %0b/%0h want 1/200", bus.imem_req, bus.imem_addr); end
    step(); bus.redirect_valid = 1'b0;
    step();
    checks++; if (bus.inst_pc !== 32'h200 || bus.inst_data !== 32'h80 || bus.inst_pc4 !== 32'h204) begin errors++; $display("FAIL al_head: got %0h/%0h/%0h want 200/80/204", bus.inst_pc, bus.inst_data, bus.inst_pc4); end
  endtask

  task automatic test_redirect_limit();
    bus.redirect_valid = 1'b1; bus.redirect_pc = LIMIT + 32'h4;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL oor_req: got %0b want 0", bus.imem_req); end
    step(); bus.redirect_valid = 1'b0; #1;
    checks++; if (halted !== 1'b1) begin errors++; $display("FAIL oor_halted: got %0b want 1", halted); end
    checks++; if (occupancy !== 3'd0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL oor_flush: got %0d/%0b want 0/0", occupancy, bus.inst_valid); end
    step(); step();
    checks++; if (bus.imem_req !== 1'b0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL oor_quiet: got %0b/%0b want 0/0", bus.imem_req, bus.inst_valid); end
  endtask

  task automatic test_pc_limit();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h3F0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h3F0) begin errors++; $display("FAIL lim_start: got %0b/%0h want 1/3f0", bus.imem_req, bus.imem_addr); end
    step(); bus.redirect_valid = 1'b0; #1;
    for (int i = 1; i <= 3; i++) begin
      if (i > 1) step();
      checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'(32'h3F0 + 4*i) || halted !== 1'b0) begin errors++; $display("FAIL lim_req i%0d: got %0b/%0h/h%0b want 1/%0h/h0", i, bus.imem_req, bus.imem_addr, halted, 32'h3F0 + 4*i); end
    end
    step();
    checks++; if (halted !== 1'b1 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL lim_halt: got h%0b/r%0b want h1/r0", halted, bus.imem_req); end
    checks++; if (bus.inst_pc !== 32'h3F8) begin errors++; $display("FAIL lim_head: got %0h want 3f8", bus.inst_pc); end
    step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h3FC) begin errors++; $display("FAIL lim_last: got %0b/%0h want 1/3fc", bus.inst_valid, bus.inst_pc); end
    step();
    checks++; if (bus.inst_valid !== 1'b0 || bus.inst_pc !== 32'h3FC || bus.inst_data !== 32'hFF) begin errors++; $display("FAIL lim_empty_hold: got %0b/%0h/%0h want 0/3fc/ff", bus.inst_valid, bus.inst_pc, bus.inst_data); end
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL lim_restart: got %0b/%0h want 1/0", bus.imem_req, bus.imem_addr); end
    step(); bus.redirect_valid = 1'b0; #1;
    checks++; if (halted !== 1'b0 || bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h4) begin errors++; $display("FAIL lim_resume: got h%0b/%0b/%0h want h0/1/4", halted, bus.imem_req, bus.imem_addr); end
  endtask

  task automatic test_reset_inflight();
    reset = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0b want 0", bus.imem_req); end
    step();
    checks++; if (occupancy !== 3'd0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_flush: got %0d/%0b want 0/0", occupancy, bus.inst_valid); end
    reset = 1'b0;
    #1;
    checks++; if (occupancy !== 3'd0 || bus.inst_valid !== 1'b0) begin errors++; $display("FAIL rst_no_late_rsp: got %0d/%0b want 0/0", occupancy, bus.inst_valid); end
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL rst_restart: got %0b/%0h want 1/0", bus.imem_req, bus.imem_addr); end
    step(); step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h0) begin errors++; $display("FAIL rst_head: got %0b/%0h/%0h want 1/0/0", bus.inst_valid, bus.inst_pc, bus.inst_data); end
  endtask

  task automatic test_run_drop();
    run = 1'b0;
    #1;
    checks++; if (bus.imem_req !== 1'b0) begin errors++; $display("FAIL run0_req: got %0b want 0", bus.imem_req); end
    step();
    checks++; if (occupancy !== 3'd0 || bus.inst_valid !== 1'b0 || halted !== 1'b0) begin errors++; $display("FAIL run0_flush: got %0d/%0b/h%0b want 0/0/h0", occupancy, bus.inst_valid, halted); end
    step();
    checks++; if (bus.inst_valid !== 1'b0 || bus.imem_req !== 1'b0) begin errors++; $display("FAIL run0_quiet: got %0b/%0b want 0/0", bus.inst_valid, bus.imem_req); end
    run = 1'b1;
    #1;
    checks++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 32'h0) begin errors++; $display("FAIL run1_restart: got %0b/%0h want 1/0", bus.imem_req, bus.imem_addr); end
    step(); step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h0 || bus.inst_data !== 32'h0) begin errors++; $display("FAIL run1_head0: got %0b/%0h/%0h want 1/0/0", bus.inst_valid, bus.inst_pc, bus.inst_data); end
    step();
    checks++; if (bus.inst_valid !== 1'b1 || bus.inst_pc !== 32'h4 || bus.inst_data !== 32'h1) begin errors++; $display("FAIL run1_head1: got %0b/%0h/%0h want 1/4/1", bus.inst_valid, bus.inst_pc, bus.inst_data); end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_flush();
    test_redirect_align();
    test_redirect_limit();
    test_pc_limit();
    test_reset_inflight();
    test_run_drop();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire

// File: doc/ifetch_prefetch_queue.md
# ifetch_prefetch_queue

Parametrised instruction-fetch front end for the single-issue MIPS-style CPU. It is the successor to the single-PC fetch stage. It owns the fetch PC and issues word reads to a synchronous 1-cycle-latency instruction ROM. Returned instructions are buffered, with their PC, in a DEPTH-entry FIFO that feeds decode through a valid/ready handshake. Branch, jump and jr resolution arrives as a single redirect, which flushes all younger work.

## Interface
Parameters:
- ADDR_W, 32: fetch address width (byte address).
- DEPTH, 4: prefetch queue entries; power of two, ≥2. Full rate needs ≥3.
- RESET_PC, 0: PC after reset or while run=0. Word aligned.
- PC_LIMIT, 32'h0000_FFFC: last fetchable word address; fetch halts after it.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  reset, synchronous, active-high.
- run  in  1  fetch enable (programmer done / CPU inited). 0 = synchronous clear to RESET_PC.
- imem_req  out  1  read strobe to ROM this cycle.
- imem_addr  out  ADDR_W  byte address of read; bits [1:0] always 0.
- imem_rdata  in  32  ROM data; valid the cycle after the matching imem_req.
- redirect_valid  in  1  taken branch / j / jal / jr this cycle.
- redirect_pc  in  ADDR_W  new fetch target; bits [1:0] ignored.
- inst_valid  out  1  queue head valid.
- inst_ready  in  1  decode accepts head.
- inst_data  out  32  head instruction.
- inst_pc  out  ADDR_W  head PC.
- inst_pc4  out  ADDR_W  inst_pc+4 (branch base / link address), modulo 2^ADDR_W.
- occupancy  out  $clog2(DEPTH+1)  entries held.
- halted  out  1  fetch stopped at PC_LIMIT or out-of-range target.

## Operation
- State:
  - fetch_pc.
  - rsp_pending, plus the PC of the pending read.
  - FIFO rd/wr pointers and count, with wrap at DEPTH.
  - halted.
- Credit: a normal issue is allowed when run & ~halted & (count + rsp_pending < DEPTH).
- On issue:
  - imem_addr = fetch_pc.
  - rsp_pending ← 1.
  - fetch_pc ← fetch_pc+4.
  - If fetch_pc == PC_LIMIT, halted ← 1 instead of advancing.
- Response: when rsp_pending is set, imem_rdata and the pending PC are written at the FIFO tail at the end of that cycle.
- Pop: inst_valid & inst_ready advances the head. Push and pop in the same cycle leave count unchanged.
- Redirect (priority over normal fetch, pop and response write):
  - Queue flushed (count ← 0, pointers equal).
  - The response arriving this cycle is discarded.
  - A handshake this cycle does not count.
  - Target = {redirect_pc[ADDR_W-1:2], 2'b00}.
  - If target ≤ PC_LIMIT: imem_req=1 in the same cycle, imem_addr=target, fetch_pc ← target+4, halted ← 0.
  - Otherwise: no request, halted ← 1.
- run=0: equivalent to reset except output timing.
  - fetch_pc ← RESET_PC, queue flushed, rsp_pending ← 0, halted ← 0, imem_req=0.
  - A response arriving in the first cycle of run=0 is discarded.
- Reset values:
  - imem_req=0, imem_addr=RESET_PC.
  - inst_valid=0, inst_data=0, inst_pc=RESET_PC, inst_pc4=RESET_PC+4.
  - occupancy=0, halted=0, rsp_pending=0.
- Reset mid-operation: a pre-reset in-flight response is never written, because rsp_pending is cleared.

## Timing
- imem_req, imem_addr: combinational from state, run and redirect inputs. inst_* and occupancy: registered/FIFO-head only; no combinational path from inst_ready.
- Latency: request in cycle N → data written end of N+1 → inst_valid in N+2.
- Redirect in cycle R → target instruction at the head in R+2.
- First request: the first cycle with reset=0 and run=1.
- Throughput: DEPTH≥3 with inst_ready held high sustains 1 instruction/cycle. DEPTH=2 sustains 1 per 2 cycles.
- Full: count+rsp_pending=DEPTH blocks issue. The queue never overflows and never drops a non-redirected response.
- Empty: inst_valid=0; inst_data/inst_pc hold the last head contents.

## Test plan
- Reset, run=1, inst_ready=1, ROM[i]=i → imem_addr 0,4,8…; inst_valid first high 2 cycles after the first req, then continuous. Data 0,1,2…; inst_pc4=inst_pc+4.
- inst_ready=0 for 10 cycles, DEPTH=4 → exactly 4 requests, occupancy=4, imem_req=0. Release → in-order drain, no lost or duplicated PCs.
- Redirect to 0x100 while occupancy=3 and a response is pending → next cycle occupancy=0. Head two cycles later has inst_pc=0x100; no stale instruction ever valid.
- redirect_pc=0x202 → fetch at 0x200.
- redirect to PC_LIMIT+4 → halted=1, no req.
- PC_LIMIT=0x10 → last req at 0x10, halted=1. A redirect to 0 clears halted and restarts fetch.
- Assert reset, then separately drop run, while a request is in flight → following cycles occupancy=0, inst_valid=0. Restart fetches RESET_PC.
